count_monitor: RTL and testbench

- Synthesizable observer for the up/down counter's output bus.
- Samples `count` and `up_count` every clock and predicts the next value. It flags any deviation, keeps a saturating error tally and reports matched wrap-around events.
- Sits beside a counter instance, in silicon or in benches, as the receiving end of the counter interface.

---
 rtl/count_monitor.sv | 159 +++++++++++++++
 tb/tb_count_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : count_monitor
// Purpose  : Observer for an up/down counter bus. It predicts the next sample
//            from the current count and direction, locks after LOCK_CNT
//            consecutive correct predictions, flags deviations while locked,
//            keeps a saturating error tally and reports matched wrap events.
// Ports    : clk        - system clock, all sampling on posedge
//            rst_n      - asynchronous active-low reset
//            en         - monitor enable, low forces IDLE
//            clr        - synchronous clear of err_count, restarts acquisition
//            count      - observed counter value [WIDTH-1:0]
//            up_count   - observed direction, 1 = up, 0 = down
//            locked     - high while tracking
//            err_pulse  - one-cycle strobe on a mismatch while locked
//            err_count  - saturating count of err_pulse events [ERR_WIDTH-1:0]
//            wrap_pulse - one-cycle strobe on a matched wrap transition
//            expected   - predicted value of the next sample [WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module count_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_WIDTH = 8,
  parameter int LOCK_CNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     count,
  input  logic                 up_count,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 wrap_pulse,
  output logic [WIDTH-1:0]     expected
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t               state, state_nx;
  logic                 exp_valid, exp_valid_nx;
  logic                 wrap_flag, wrap_flag_nx;
  logic [3:0]           match_cnt, match_cnt_nx;
  logic [3:0]           match_inc;
  logic [WIDTH-1:0]     expected_nx;
  logic [WIDTH-1:0]     pred;
  logic                 wrap_cond;
  logic                 hit;
  logic                 locked_nx;
  logic                 err_pulse_nx;
  logic                 wrap_pulse_nx;
  logic [ERR_WIDTH-1:0] err_count_nx;

  // Prediction for the sample after this one, modulo 2^WIDTH.
  assign pred      = up_count ? count + WIDTH'(1) : count - WIDTH'(1);
  assign wrap_cond = up_count ? (&count) : ~(|count);
  assign hit       = exp_valid && (count == expected);
  assign match_inc = match_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_valid  <= 1'b0;
      wrap_flag  <= 1'b0;
      match_cnt  <= '0;
      expected   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nx;
      exp_valid  <= exp_valid_nx;
      wrap_flag  <= wrap_flag_nx;
      match_cnt  <= match_cnt_nx;
      expected   <= expected_nx;
      locked     <= locked_nx;
      err_pulse  <= err_pulse_nx;
      wrap_pulse <= wrap_pulse_nx;
      err_count  <= err_count_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    exp_valid_nx  = exp_valid;
    wrap_flag_nx  = wrap_flag;
    match_cnt_nx  = match_cnt;
    expected_nx   = expected;
    err_count_nx  = err_count;
    err_pulse_nx  = 1'b0;
    wrap_pulse_nx = 1'b0;

    if (!en) begin
      state_nx     = IDLE;
      exp_valid_nx = 1'b0;
      match_cnt_nx = '0;
    end else if (clr) begin
      state_nx     = ACQUIRE;
      exp_valid_nx = 1'b0;
      match_cnt_nx = '0;
      err_count_nx = '0;
    end else begin
      // Every enabled sample refreshes the prediction; after a mismatch this
      // resynchronises to the observed value so one glitch is one error.
      expected_nx  = pred;
      wrap_flag_nx = wrap_cond;
      exp_valid_nx = 1'b1;

      unique case (state)
        IDLE: begin
          state_nx     = ACQUIRE;
          match_cnt_nx = '0;
        end
        ACQUIRE: begin
          if (!exp_valid) begin
            match_cnt_nx = '0;
          end else if (hit) begin
            match_cnt_nx  = match_inc;
            wrap_pulse_nx = wrap_flag;
            if (match_inc >= LOCK_TGT) begin
              state_nx = TRACK;
            end
          end else begin
            match_cnt_nx = '0;
          end
        end
        TRACK: begin
          if (hit) begin
            wrap_pulse_nx = wrap_flag;
          end else begin
            err_pulse_nx = 1'b1;
            if (~&err_count) begin
              err_count_nx = err_count + ERR_WIDTH'(1);
            end
            state_nx     = ACQUIRE;
            match_cnt_nx = '0;
          end
        end
        default: begin
          state_nx     = IDLE;
          exp_valid_nx = 1'b0;
          match_cnt_nx = '0;
        end
      endcase
    end

    locked_nx = (state_nx == TRACK);
  end

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_monitor
// Purpose  : Self-checking bench for count_monitor. Two instances share the
//            stimulus: one with an 8-bit error counter, one with a 2-bit
//            error counter to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [3:0] count;
  logic       up_count;

  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count;
  logic [3:0] expected;
  logic       locked2, err_pulse2, wrap_pulse2;
  logic [1:0] err_count2;
  logic [3:0] expected2;

  always #5 clk = ~clk;

  count_monitor #(.WIDTH(4), .ERR_WIDTH(8), .LOCK_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .count(count),
    .up_count(up_count), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .wrap_pulse(wrap_pulse), .expected(expected)
  );

  count_monitor #(.WIDTH(4), .ERR_WIDTH(2), .LOCK_CNT(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .count(count),
    .up_count(up_count), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .wrap_pulse(wrap_pulse2), .expected(expected2)
  );

  typedef struct packed {
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] ec;
    logic [1:0] ec2;
    logic [3:0] exp;
  } outs_t;

  typedef struct {
    logic  en;
    logic  clr;
    logic [3:0] cnt;
    logic  up;
    outs_t want;
  } vec_t;

  outs_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model state (behavioural description of the monitor).
  int         m_state = 0;   // 0 idle, 1 acquire, 2 track
  logic       m_valid = 1'b0;
  logic [3:0] m_exp   = 4'd0;
  logic       m_wf    = 1'b0;
  int         m_mc    = 0;
  logic [7:0] m_ec    = 8'd0;
  logic [1:0] m_ec2   = 2'd0;

  // Bench-side counter driving the bus.
  logic [3:0] bc = 4'd0;
  logic       bd = 1'b1;

  function automatic outs_t mk(input logic l, e, w, input logic [7:0] ec,
                               input logic [1:0] ec2, input logic [3:0] ex);
    outs_t o;
    o.locked = l; o.err = e; o.wrap = w; o.ec = ec; o.ec2 = ec2; o.exp = ex;
    return o;
  endfunction

  task automatic model_step(input logic e, cl, input logic [3:0] c,
                            input logic u, output outs_t o);
    logic err, wrap, hit;
    err  = 1'b0;
    wrap = 1'b0;
    if (!e) begin
      m_state = 0; m_valid = 1'b0; m_mc = 0;
    end else if (cl) begin
      m_state = 1; m_valid = 1'b0; m_mc = 0; m_ec = 8'd0; m_ec2 = 2'd0;
    end else begin
      hit = m_valid && (c == m_exp);
      if (m_state == 0) begin
        m_state = 1; m_mc = 0;
      end else if (m_state == 1) begin
        if (!m_valid)   m_mc = 0;
        else if (hit) begin
          m_mc = m_mc + 1;
          wrap = m_wf;
          if (m_mc == 2) m_state = 2;
        end else        m_mc = 0;
      end else begin
        if (hit) wrap = m_wf;
        else begin
          err = 1'b1;
          if (m_ec  != 8'hFF) m_ec  = m_ec + 8'd1;
          if (m_ec2 != 2'd3)  m_ec2 = m_ec2 + 2'd1;
          m_state = 1; m_mc = 0;
        end
      end
      m_exp   = u ? c + 4'd1 : c - 4'd1;
      m_wf    = u ? (c == 4'hF) : (c == 4'h0);
      m_valid = 1'b1;
    end
    o = mk(m_state == 2, err, wrap, m_ec, m_ec2, m_exp);
  endtask

  task automatic check_front(input string name);
    outs_t got, want;
    got = mk(locked, err_pulse, wrap_pulse, err_count, err_count2, expected);
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
      return;
    end
    want = sb_q.pop_front();
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got locked=%b err=%b wrap=%b ec=%0d ec2=%0d exp=%h, want locked=%b err=%b wrap=%b ec=%0d ec2=%0d exp=%h",
               name, got.locked, got.err, got.wrap, got.ec, got.ec2, got.exp,
               want.locked, want.err, want.wrap, want.ec, want.ec2, want.exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Drive one sample at negedge, push its expectation, compare after posedge.
  task automatic drive(input logic e, cl, input logic [3:0] c, input logic u,
                       input outs_t want, input string name);
    @(negedge clk);
    en = e; clr = cl; count = c; up_count = u;
    sb_q.push_back(want);
    @(posedge clk);
    #1;
    check_front(name);
  endtask

  task automatic drive_model(input logic e, cl, input string name);
    outs_t w;
    model_step(e, cl, bc, bd, w);
    drive(e, cl, bc, bd, w, name);
    bc = bd ? bc + 4'd1 : bc - 4'd1;
  endtask

  task automatic tick(input string name);
    drive_model(1'b1, 1'b0, name);
  endtask

  initial begin
    vec_t tbl[6];
    outs_t dummy;
    int wraps, errs;
    int sat_want[5];

    tbl[0] = '{1'b0, 1'b0, 4'd0, 1'b1, mk(0, 0, 0, 8'd0, 2'd0, 4'd0)};
    tbl[1] = '{1'b1, 1'b0, 4'd0, 1'b1, mk(0, 0, 0, 8'd0, 2'd0, 4'd1)};
    tbl[2] = '{1'b1, 1'b0, 4'd1, 1'b1, mk(0, 0, 0, 8'd0, 2'd0, 4'd2)};
    tbl[3] = '{1'b1, 1'b0, 4'd2, 1'b1, mk(1, 0, 0, 8'd0, 2'd0, 4'd3)};
    tbl[4] = '{1'b1, 1'b0, 4'd3, 1'b1, mk(1, 0, 0, 8'd0, 2'd0, 4'd4)};
    tbl[5] = '{1'b1, 1'b0, 4'd4, 1'b1, mk(1, 0, 0, 8'd0, 2'd0, 4'd5)};
    sat_want = '{1, 2, 3, 3, 3};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; count = 4'd0; up_count = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({locked, err_pulse, wrap_pulse, err_count, err_count2, expected}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquisition from count 0: locked at the edge sampling 2.
    for (int i = 0; i < 6; i++) begin
      model_step(tbl[i].en, tbl[i].clr, tbl[i].cnt, tbl[i].up, dummy);
      drive(tbl[i].en, tbl[i].clr, tbl[i].cnt, tbl[i].up, tbl[i].want,
            $sformatf("table[%0d]", i));
    end
    bc = 4'd5; bd = 1'b1;

    // Up sweep 5..F,0: exactly one wrap, at the sample of 0.
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      tick("up_sweep");
      wraps += int'(wrap_pulse);
      if (bc == 4'd1) chk("up_wrap_at_zero", int'(wrap_pulse), 1);
    end
    chk("up_wrap_count", wraps, 1);
    chk("up_no_errors", int'(err_count), 0);

    // Up to 9, then the counter is reset under the monitor.
    while (bc != 4'd10) tick("up_to_9");
    bc = 4'd0;
    tick("glitch");
    chk("glitch_err_pulse", int'(err_pulse), 1);
    chk("glitch_err_count", int'(err_count), 1);
    chk("glitch_unlocked", int'(locked), 0);
    tick("relock_1");
    chk("relock_1_locked", int'(locked), 0);
    tick("relock_2");
    chk("relock_2_locked", int'(locked), 1);

    // Direction flip while count = 7, then down through the wrap.
    while (bc != 4'd7) tick("up_to_7");
    bd = 1'b0;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      tick("flip");
      errs += int'(err_pulse);
      chk("flip_locked", int'(locked), 1);
    end
    chk("flip_no_err", errs, 0);
    wraps = 0;
    for (int i = 0; i < 7; i++) begin
      tick("down_sweep");
      wraps += int'(wrap_pulse);
      if (bc == 4'hE) chk("down_wrap_at_F", int'(wrap_pulse), 1);
    end
    chk("down_wrap_count", wraps, 1);

    // Synchronous clear, then relock after two matches.
    drive_model(1'b1, 1'b1, "clr");
    chk("clr_err_count", int'(err_count), 0);
    chk("clr_unlocked", int'(locked), 0);
    for (int i = 0; i < 3; i++) tick("clr_relock");
    chk("clr_relocked", int'(locked), 1);

    // Enable drop mid-track: IDLE, error count retained, then reacquire.
    bd = 1'b1;
    drive_model(1'b0, 1'b0, "en_low");
    for (int i = 0; i < 3; i++) tick("en_relock");
    chk("en_relocked", int'(locked), 1);

    // Five glitches, each followed by clean cycles; 2-bit tally saturates.
    errs = 0;
    for (int g = 0; g < 5; g++) begin
      bc = 4'd0;
      tick("sat_glitch");
      errs += int'(err_pulse2);
      chk($sformatf("sat_ec2[%0d]", g), int'(err_count2), sat_want[g]);
      for (int i = 0; i < 5; i++) begin
        tick("sat_clean");
        errs += int'(err_pulse2);
      end
    end
    chk("sat_pulse_total", errs, 5);
    chk("sat_wide_count", int'(err_count), 5);
    chk("sat_locked", int'(locked), 1);

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset",
        int'({locked, err_pulse, wrap_pulse, err_count, err_count2, expected,
              locked2, err_pulse2, wrap_pulse2, expected2}), 0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
